// File: rtl/msu_sq_arbiter_if.sv
// Bundle of requester, response and squarer-side signals for msu_sq_arbiter.
// slave = arbiter view, master = requesters/squarer/response-sink view.
interface msu_sq_arbiter_if #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned SQ_IN_BITS  = 1024,
  parameter int unsigned SQ_OUT_BITS = 1056,
  parameter int unsigned T_LEN       = 64
) ();
  localparam int unsigned IdW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*SQ_IN_BITS-1:0] req_sq_in;
  logic [NUM_REQ*T_LEN-1:0]      req_t_count;

  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [IdW-1:0]                rsp_id;
  logic [SQ_OUT_BITS-1:0]        rsp_sq_out;
  logic [T_LEN-1:0]              rsp_t_done;
  logic                          rsp_err;

  logic                          sq_reset;
  logic                          sq_start;
  logic [SQ_IN_BITS-1:0]         sq_in;
  logic [SQ_OUT_BITS-1:0]        sq_out;
  logic                          sq_valid;

  modport slave (
    input  req_valid, req_sq_in, req_t_count, rsp_ready, sq_out, sq_valid,
    output req_ready, rsp_valid, rsp_id, rsp_sq_out, rsp_t_done, rsp_err,
           sq_reset, sq_start, sq_in
  );

  modport master (
    output req_valid, req_sq_in, req_t_count, rsp_ready, sq_out, sq_valid,
    input  req_ready, rsp_valid, rsp_id, rsp_sq_out, rsp_t_done, rsp_err,
           sq_reset, sq_start, sq_in
  );
endinterface

// File: rtl/msu_sq_arbiter.sv
// Round-robin job scheduler sharing one modular squarer between NUM_REQ requesters.
// Define MSU_SQ_ARB_TIMEOUT_EN to enable the RUN-state watchdog (rsp_err).
module msu_sq_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned SQ_IN_BITS  = 1024,
  parameter int unsigned SQ_OUT_BITS = 1056,
  parameter int unsigned T_LEN       = 64,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input logic             clk,
  input logic             reset_n,
  msu_sq_arbiter_if.slave bus
);
  localparam int unsigned IdW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StStart, StRun, StResp} state_e;

  state_e                 r_state, w_state_next;
  logic [1:0]             r_rst_sync;
  logic [IdW-1:0]         r_last_grant, r_rsp_id, w_winner;
  logic                   w_found, w_hs, w_final, w_abort;
  logic [SQ_IN_BITS-1:0]  r_sq_in, w_sel_sq_in;
  logic [T_LEN-1:0]       r_t_target, r_iter_cnt, r_rsp_t_done, w_sel_t_count;
  logic [SQ_OUT_BITS-1:0] r_rsp_sq_out;

  function automatic logic [IdW-1:0] rr_idx(input logic [IdW-1:0] base, input int unsigned k);
    return IdW'((32'(base) + k) % NUM_REQ);
  endfunction

  // Grants stay blocked until reset release has passed through both sync flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= '0;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && bus.req_valid[rr_idx(r_last_grant, k)]) begin
        w_found  = 1'b1;
        w_winner = rr_idx(r_last_grant, k);
      end
    end
  end

  assign w_hs          = (r_state == StIdle) && w_found && r_rst_sync[1];
  assign w_sel_sq_in   = bus.req_sq_in[w_winner*SQ_IN_BITS +: SQ_IN_BITS];
  assign w_sel_t_count = bus.req_t_count[w_winner*T_LEN +: T_LEN];
  assign w_final       = (r_state == StRun) && bus.sq_valid &&
                         ((r_iter_cnt + T_LEN'(1)) == r_t_target);

`ifdef MSU_SQ_ARB_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);

  logic [WdW-1:0] r_wdog;
  logic           r_rsp_err;

  // Abort on the edge where the idle-cycle count would reach TIMEOUT_CYC.
  assign w_abort = (r_state == StRun) && !bus.sq_valid &&
                   (r_wdog == WdW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog    <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (r_state == StStart) r_wdog <= '0;
      else if (r_state == StRun) r_wdog <= bus.sq_valid ? '0 : r_wdog + WdW'(1);
      if (w_hs)    r_rsp_err <= 1'b0;
      if (w_abort) r_rsp_err <= 1'b1;
    end
  end

  assign bus.rsp_err = r_rsp_err;
`else
  assign w_abort     = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_hs) w_state_next = (w_sel_t_count == '0) ? StResp : StStart;
      StStart: w_state_next = StRun;
      StRun:   if (w_final || w_abort) w_state_next = StResp;
      StResp:  if (bus.rsp_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    bus.sq_start  = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.sq_reset  = 1'b1;
    unique case (r_state)
      StIdle:  if (w_hs) bus.req_ready[w_winner] = 1'b1;
      StStart: begin
        bus.sq_start = 1'b1;
        bus.sq_reset = 1'b0;
      end
      StRun:   bus.sq_reset = 1'b0;
      StResp:  bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= IdW'(NUM_REQ - 1);
      r_rsp_id     <= '0;
      r_sq_in      <= '0;
      r_t_target   <= '0;
      r_iter_cnt   <= '0;
      r_rsp_sq_out <= '0;
      r_rsp_t_done <= '0;
    end else begin
      if (w_hs) begin
        r_sq_in      <= w_sel_sq_in;
        r_t_target   <= w_sel_t_count;
        r_rsp_id     <= w_winner;
        r_last_grant <= w_winner;
        // Zero-count jobs bypass the squarer and echo the start value.
        if (w_sel_t_count == '0) begin
          r_rsp_sq_out <= SQ_OUT_BITS'(w_sel_sq_in);
          r_rsp_t_done <= '0;
        end
      end
      if (r_state == StStart) r_iter_cnt <= '0;
      if (r_state == StRun && bus.sq_valid) r_iter_cnt <= r_iter_cnt + T_LEN'(1);
      if (w_final) begin
        r_rsp_sq_out <= bus.sq_out;
        r_rsp_t_done <= r_t_target;
      end
      if (w_abort) begin
        r_rsp_sq_out <= '0;
        r_rsp_t_done <= r_iter_cnt;
      end
    end
  end

  assign bus.sq_in      = r_sq_in;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_sq_out = r_rsp_sq_out;
  assign bus.rsp_t_done = r_rsp_t_done;
endmodule

// File: tb/tb_msu_sq_arbiter.sv
// Self-checking bench for msu_sq_arbiter: table of directed jobs plus hand-written
// reset, mid-job reset and (when MSU_SQ_ARB_TIMEOUT_EN is defined) watchdog sequences.
module tb_msu_sq_arbiter;
  localparam int unsigned NumReq = 4;
  localparam int unsigned InW    = 16;
  localparam int unsigned OutW   = 20;
  localparam int unsigned TW     = 8;
  localparam int unsigned Tmo    = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  msu_sq_arbiter_if #(
    .NUM_REQ(NumReq), .SQ_IN_BITS(InW), .SQ_OUT_BITS(OutW), .T_LEN(TW)
  ) bus ();

  msu_sq_arbiter #(
    .NUM_REQ(NumReq), .SQ_IN_BITS(InW), .SQ_OUT_BITS(OutW), .T_LEN(TW), .TIMEOUT_CYC(Tmo)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {
    logic [3:0]  mask;
    logic [7:0]  cnt;
    logic [11:0] val;
    int          exp_id;
    int          gap;
    int          bp;
  } job_t;

  job_t jobs[9];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requester i presents {i, val} so the granted slot is visible in sq_in.
  task automatic drive_reqs(input logic [3:0] mask, input logic [7:0] cnt,
                            input logic [11:0] val);
    bus.req_valid = mask;
    for (int i = 0; i < NumReq; i++) begin
      bus.req_sq_in[i*InW +: InW]  = {4'(i), val};
      bus.req_t_count[i*TW +: TW] = cnt;
    end
  endtask

  task automatic do_reset(input logic [3:0] mask, input logic [3:0] exp_rdy);
    reset_n = 1'b0;
    drive_reqs(mask, 8'd1, 12'h000);
    #1;
    chk("rst_ctrl", {bus.req_ready, bus.sq_start, bus.rsp_valid, bus.sq_reset}, 7'b0000001);
    chk("rst_regs", {bus.sq_in, bus.rsp_id, bus.rsp_sq_out, bus.rsp_t_done, bus.rsp_err}, '0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst_sync1", {bus.req_ready, bus.rsp_valid}, 5'b0);
    tick();
    chk("rst_sync2", {bus.req_ready, bus.rsp_valid}, {exp_rdy, 1'b0});
  endtask

  task automatic finish_rsp();
    bus.sq_valid  = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    chk("no_grant_in_resp", bus.req_ready, '0);
    tick();
    bus.rsp_ready = 1'b0;
    bus.req_valid = '0;
    #1;
    chk("rsp_done", {bus.rsp_valid, bus.sq_reset}, 2'b01);
  endtask

  task automatic run_job(input job_t j);
    logic [InW-1:0]  exp_in;
    logic [OutW-1:0] exp_out;
    logic [3:0]      exp_rdy;
    int              n;
    exp_in  = {4'(j.exp_id), j.val};
    exp_out = (j.cnt == 0) ? OutW'(exp_in) : OutW'(32'h11 * j.cnt);
    exp_rdy = 4'b0001 << j.exp_id;
    drive_reqs(j.mask, j.cnt, j.val);
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 8) begin
      tick();
      n++;
    end
    chk("grant", bus.req_ready, exp_rdy);
    chk("sq_reset_idle", bus.sq_reset, 1'b1);
    tick();
    if (j.cnt == 0) begin
      chk("zero_cnt", {bus.rsp_valid, bus.sq_start}, 2'b10);
    end else begin
      chk("start", {bus.sq_start, bus.sq_reset, bus.rsp_valid}, 3'b100);
      chk("sq_in", bus.sq_in, exp_in);
      tick();
      chk("run", {bus.sq_start, bus.sq_reset, bus.req_ready}, '0);
      for (int k = 1; k <= int'(j.cnt); k++) begin
        bus.sq_valid = 1'b1;
        bus.sq_out   = OutW'(32'h11 * k);
        tick();
        bus.sq_valid = 1'b0;
        bus.sq_out   = '0;
        if (k < int'(j.cnt)) begin
          chk("no_early_rsp", bus.rsp_valid, 1'b0);
          for (int g = 0; g < j.gap; g++) tick();
        end
      end
    end
    chk("rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_sq_out, bus.rsp_t_done, bus.rsp_err,
                bus.sq_reset}, {1'b1, 2'(j.exp_id), exp_out, j.cnt, 1'b0, 1'b1});
    // Backpressure: stray squarer pulses and pending requests must not disturb RESP.
    for (int b = 0; b < j.bp; b++) begin
      bus.sq_valid = b[0];
      bus.sq_out   = '1;
      tick();
      chk("bp_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_sq_out, bus.rsp_t_done, bus.rsp_err,
                      bus.req_ready, bus.sq_start},
          {1'b1, 2'(j.exp_id), exp_out, j.cnt, 1'b0, 4'b0, 1'b0});
    end
    bus.sq_out = '0;
    finish_rsp();
  endtask

  initial begin
    jobs[0] = '{mask: 4'b1111, cnt: 8'd3, val: 12'h123, exp_id: 0, gap: 0, bp: 0};
    jobs[1] = '{mask: 4'b1111, cnt: 8'd1, val: 12'h456, exp_id: 1, gap: 0, bp: 10};
    jobs[2] = '{mask: 4'b1111, cnt: 8'd2, val: 12'h789, exp_id: 2, gap: 1, bp: 2};
    jobs[3] = '{mask: 4'b1111, cnt: 8'd4, val: 12'h0F0, exp_id: 3, gap: 1, bp: 0};
    jobs[4] = '{mask: 4'b0101, cnt: 8'd0, val: 12'hABC, exp_id: 0, gap: 0, bp: 1};
    jobs[5] = '{mask: 4'b0100, cnt: 8'd2, val: 12'h321, exp_id: 2, gap: 0, bp: 0};
    jobs[6] = '{mask: 4'b1010, cnt: 8'd1, val: 12'h654, exp_id: 3, gap: 0, bp: 0};
    jobs[7] = '{mask: 4'b1010, cnt: 8'd3, val: 12'h987, exp_id: 1, gap: 1, bp: 0};
    jobs[8] = '{mask: 4'b0001, cnt: 8'd0, val: 12'hFFF, exp_id: 0, gap: 0, bp: 0};

    bus.req_valid   = '0;
    bus.req_sq_in   = '0;
    bus.req_t_count = '0;
    bus.rsp_ready   = 1'b0;
    bus.sq_out      = '0;
    bus.sq_valid    = 1'b0;
    #2;

    do_reset(4'b1111, 4'b0001);
    for (int i = 0; i < 9; i++) run_job(jobs[i]);

    // Mid-job reset: req2 in RUN after one pulse, then req1+req0 must grant req0.
    drive_reqs(4'b0100, 8'd5, 12'h5A5);
    #1;
    chk("mid_grant", bus.req_ready, 4'b0100);
    tick();
    tick();
    bus.sq_valid = 1'b1;
    bus.sq_out   = 20'h11;
    tick();
    bus.sq_valid = 1'b0;
    chk("mid_run", {bus.sq_reset, bus.rsp_valid}, 2'b00);
    do_reset(4'b0011, 4'b0001);
    run_job('{mask: 4'b0011, cnt: 8'd1, val: 12'h5A5, exp_id: 0, gap: 0, bp: 0});
    run_job('{mask: 4'b0010, cnt: 8'd2, val: 12'h246, exp_id: 1, gap: 0, bp: 0});

`ifdef MSU_SQ_ARB_TIMEOUT_EN
    begin
      int early;
      drive_reqs(4'b1000, 8'd5, 12'h777);
      #1;
      chk("wd_grant", bus.req_ready, 4'b1000);
      tick();
      chk("wd_start", bus.sq_start, 1'b1);
      tick();
      for (int k = 1; k <= 2; k++) begin
        bus.sq_valid = 1'b1;
        bus.sq_out   = OutW'(32'h11 * k);
        tick();
        bus.sq_valid = 1'b0;
      end
      early = 0;
      for (int k = 1; k < int'(Tmo); k++) begin
        tick();
        if (bus.rsp_valid) early++;
      end
      chk("wd_no_early", 64'(early), 64'd0);
      tick();
      chk("wd_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_sq_out, bus.rsp_t_done, bus.rsp_err},
          {1'b1, 2'd3, 20'h0, 8'd2, 1'b1});
      finish_rsp();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
